mcu_core: RTL and testbench

Parametrised multi-cycle accumulator-free register CPU, successor of the team's fixed 8-bit core. It fetches 4-byte instructions over a single memory port that supports wait states, with configurable data width, register-file depth and address width. It adds zero/carry flags, conditional branches, an illegal-opcode trap and a sticky halt. It sits between the program/data memory and any memory-mapped peripherals on the same bus.

---
 rtl/mcu_pkg.sv | 42 ++++
 rtl/mcu_alu.sv | 42 ++++
 rtl/mcu_core.sv | 181 ++++++++++++++++++
 tb/tb_mcu_core.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// mcu_pkg: opcodes, FSM states and instruction field positions
// shared by the mcu_core slice.
package mcu_pkg;

  localparam logic [7:0] OP_HALT = 8'h00;
  localparam logic [7:0] OP_LD   = 8'h01;
  localparam logic [7:0] OP_ST   = 8'h02;
  localparam logic [7:0] OP_LDI  = 8'h03;
  localparam logic [7:0] OP_MOV  = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_SUB  = 8'h06;
  localparam logic [7:0] OP_AND  = 8'h07;
  localparam logic [7:0] OP_OR   = 8'h08;
  localparam logic [7:0] OP_XOR  = 8'h09;
  localparam logic [7:0] OP_SHL  = 8'h0A;
  localparam logic [7:0] OP_SHR  = 8'h0B;
  localparam logic [7:0] OP_JMP  = 8'h0C;
  localparam logic [7:0] OP_JZ   = 8'h0D;
  localparam logic [7:0] OP_JC   = 8'h0E;
  localparam logic [7:0] OP_ADC  = 8'h0F;

  localparam int OPC_LSB = 24;
  localparam int A_LSB   = 16;
  localparam int B_LSB   = 8;
  localparam int D_LSB   = 0;
  localparam int ADR_LSB = 0;
  localparam int TGT_LSB = 8;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  function automatic logic is_alu(input logic [7:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                      OP_XOR, OP_SHL, OP_SHR, OP_ADC};
  endfunction

endpackage

// File: rtl/mcu_alu.sv
// mcu_alu: combinational datapath for mcu_core.
// Result is DATA_W bits; c is carry (add) or borrow (sub).
module mcu_alu
  import mcu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [7:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c
);

  logic [DATA_W:0] sum;
  logic            ci;

  // Operation select; shifts by >= DATA_W fall out as zero
  always_comb begin
    result = '0;
    c      = 1'b0;
    ci     = (op == OP_ADC) & cin;
    sum    = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, ci};
    unique case (op)
      OP_ADD, OP_ADC: {c, result} = sum;
      OP_SUB: begin
        result = a - b;
        c      = a < b;
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: result = a << b;
      OP_SHR: result = a >> b;
      default: result = '0;
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/mcu_core.sv
// mcu_core: multi-cycle register CPU with waited memory port.
// MCU_CARRY_EN adds the C flag, JC and ADC.
module mcu_core
  import mcu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc
);

  localparam int IW = $clog2(NREGS);

  state_t            state;
  logic [1:0]        beat;
  logic [31:0]       ir;
  logic              z_q;
  logic [DATA_W-1:0] rf [NREGS];

  logic [7:0]        opc;
  logic [IW-1:0]     ia, ib, id;
  logic [DATA_W-1:0] ra, rb;
  logic [ADDR_W-1:0] daddr, tgt, pc4, npc;
  logic              legal, take, mem_op;
  logic              cin;
  logic [DATA_W-1:0] alu_res;
  logic              alu_z, alu_c;

`ifdef MCU_CARRY_EN
  logic c_q;
  assign cin = c_q;
`else
  logic unused_c;
  assign cin      = 1'b0;
  assign unused_c = alu_c;
`endif

  assign opc    = ir[OPC_LSB +: 8];
  assign ia     = ir[A_LSB +: IW];
  assign ib     = ir[B_LSB +: IW];
  assign id     = ir[D_LSB +: IW];
  assign ra     = rf[ia];
  assign rb     = rf[ib];
  assign daddr  = ir[ADR_LSB +: ADDR_W];
  assign tgt    = ir[TGT_LSB +: ADDR_W];
  assign pc4    = pc + ADDR_W'(4);
  assign npc    = take ? tgt : pc4;
  assign mem_op = (opc == OP_LD) | (opc == OP_ST);

  // Opcode legality and branch resolution
  always_comb begin
`ifdef MCU_CARRY_EN
    legal = opc <= OP_ADC;
    take  = (opc == OP_JMP) | ((opc == OP_JZ) & z_q)
          | ((opc == OP_JC) & c_q);
`else
    legal = opc <= OP_JZ;
    take  = (opc == OP_JMP) | ((opc == OP_JZ) & z_q);
`endif
  end

  mcu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (opc),
    .a      (ra),
    .b      (rb),
    .cin    (cin),
    .result (alu_res),
    .z      (alu_z),
    .c      (alu_c)
  );

  // Control FSM, bus requests, register file and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      beat      <= '0;
      ir        <= '0;
      pc        <= '0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      z_q       <= 1'b0;
`ifdef MCU_CARRY_EN
      c_q       <= 1'b0;
`endif
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (!mem_rd) begin
            mem_rd   <= 1'b1;
            mem_addr <= pc;
            beat     <= '0;
          end else if (mem_ready) begin
            ir   <= {ir[23:0], mem_rdata[7:0]};
            beat <= beat + 2'd1;
            if (beat == 2'd3) begin
              mem_rd <= 1'b0;
              state  <= S_DECODE;
            end else begin
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
        end
        S_DECODE: begin
          if (!legal || opc == OP_HALT) begin
            halted  <= 1'b1;
            illegal <= !legal;
            state   <= S_HALT;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          unique case (1'b1)
            is_alu(opc): begin
              rf[id] <= alu_res;
              z_q    <= alu_z;
`ifdef MCU_CARRY_EN
              if (opc inside {OP_ADD, OP_SUB, OP_ADC})
                c_q <= alu_c;
`endif
            end
            (opc == OP_LDI): rf[ia] <= DATA_W'(ir[B_LSB +: 8]);
            (opc == OP_MOV): rf[ia] <= rb;
            (opc == OP_LD): begin
              mem_rd   <= 1'b1;
              mem_addr <= daddr;
              state    <= S_MEM;
            end
            (opc == OP_ST): begin
              mem_wr    <= 1'b1;
              mem_addr  <= daddr;
              mem_wdata <= ra;
              state     <= S_MEM;
            end
            default: ;
          endcase
          if (!mem_op) begin
            pc       <= npc;
            mem_addr <= npc;
            mem_rd   <= 1'b1;
            beat     <= '0;
            state    <= S_FETCH;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (opc == OP_LD) begin
              rf[ia] <= mem_rdata;
              z_q    <= (mem_rdata == '0);
            end
            mem_wr   <= 1'b0;
            mem_rd   <= 1'b1;
            mem_addr <= pc4;
            pc       <= pc4;
            beat     <= '0;
            state    <= S_FETCH;
          end
        end
        S_HALT: ;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_core.sv
// tb_mcu_core: directed programs against mcu_core with
// a byte memory model, wait-state modes and bus monitors.
module tb_mcu_core;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;
  localparam int NREGS  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              halted;
  logic              illegal;
  logic [ADDR_W-1:0] pc;

  mcu_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halted    (halted),
    .illegal   (illegal),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  // 0: always ready, 1: two wait cycles per request, 2: writes stall
  int         mode = 0;
  logic [1:0] wcnt;
  logic [7:0] mem [0:65535];

  assign mem_rdata = mem[mem_addr];
  assign mem_ready = (mode == 0) ? 1'b1 :
                     (mode == 1) ? (wcnt == 2'd2) : !mem_wr;

  int          wr_cnt, rd_cnt, stab_err;
  logic [15:0] wl_addr [0:7];
  logic [7:0]  wl_data [0:7];
  logic        held;
  logic [25:0] hold_v;

  // Wait-state counter and completed-transfer log
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt   <= '0;
      wr_cnt <= 0;
      rd_cnt <= 0;
    end else begin
      if ((mem_rd || mem_wr) && !mem_ready) wcnt <= wcnt + 2'd1;
      else wcnt <= '0;
      if (mem_rd && mem_ready) rd_cnt <= rd_cnt + 1;
      if (mem_wr && mem_ready) begin
        if (wr_cnt < 8) begin
          wl_addr[wr_cnt[2:0]] <= mem_addr;
          wl_data[wr_cnt[2:0]] <= mem_wdata;
        end
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  // Request must stay stable while not ready; rd and wr exclusive
  always @(negedge clk) begin
    if (rst) begin
      held     <= 1'b0;
      stab_err <= 0;
    end else begin
      if ((held && ({mem_rd, mem_wr, mem_addr, mem_wdata} !== hold_v))
          || (mem_rd && mem_wr))
        stab_err <= stab_err + 1;
      held   <= (mem_rd || mem_wr) && !mem_ready;
      hold_v <= {mem_rd, mem_wr, mem_addr, mem_wdata};
    end
  end

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input int adr, input logic [31:0] w);
    mem[adr]     = w[31:24];
    mem[adr + 1] = w[23:16];
    mem[adr + 2] = w[15:8];
    mem[adr + 3] = w[7:0];
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  endtask

  task automatic chk_rst(input string tag);
    chk(tag, {mem_addr, mem_rd, mem_wr, mem_wdata,
              halted, illegal, pc}, 64'h0);
  endtask

  task automatic do_reset(input int m);
    rst  = 1'b1;
    mode = m;
    @(posedge clk);
    #1;
    chk_rst("reset_state");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_halt(input int budget, output int cyc);
    cyc = 0;
    while (halted !== 1'b1 && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("halt_reached", halted, 1);
  endtask

  task automatic prog_add_st();
    clear_mem();
    put(0,  32'h03_01_05_00);
    put(4,  32'h03_02_03_00);
    put(8,  32'h05_01_02_03);
    put(12, 32'h02_03_01_00);
    put(16, 32'h00_00_00_00);
  endtask

  task automatic prog_sub(input logic [7:0] r2v, input logic tail_jc);
    clear_mem();
    put(0, 32'h03_01_04_00);
    put(4, {16'h03_02, r2v, 8'h00});
    put(8, 32'h06_01_02_03);
    if (tail_jc) begin
      put(12, 32'h02_03_02_00);
      put(16, 32'h0E_00_40_00);
    end else begin
      put(12, 32'h0D_00_20_00);
    end
  endtask

  int cyc;

  initial begin
    // ADD then store, zero wait
    prog_add_st();
    do_reset(0);
    run_halt(200, cyc);
    chk("add_halt_cycle", cyc, 31);
    chk("add_wr_cnt", wr_cnt, 1);
    chk("add_wr_addr", wl_addr[0], 16'h0100);
    chk("add_wr_data", wl_data[0], 8'h08);
    chk("add_pc", pc, 16);
    chk("add_illegal", illegal, 0);
    chk("add_fetch_reads", rd_cnt, 20);

    // Same program, two wait cycles on every request
    prog_add_st();
    do_reset(1);
    run_halt(400, cyc);
    chk("wait_halt_cycle", cyc, 73);
    chk("wait_wr_cnt", wr_cnt, 1);
    chk("wait_wr", {wl_addr[0], wl_data[0]}, {16'h0100, 8'h08});
    chk("wait_pc", pc, 16);
    chk("wait_stable", stab_err, 0);

    // SUB equal -> Z set, JZ taken
    prog_sub(8'h04, 1'b0);
    do_reset(0);
    run_halt(200, cyc);
    chk("jz_taken_pc", pc, 16'h0020);
    chk("jz_taken_ill", illegal, 0);

    // SUB 4-5 -> Z clear, JZ falls through
    prog_sub(8'h05, 1'b0);
    do_reset(0);
    run_halt(200, cyc);
    chk("jz_not_taken_pc", pc, 16);

    // SUB borrow result stored, then JC
    prog_sub(8'h05, 1'b1);
    do_reset(0);
    run_halt(200, cyc);
    chk("sub_borrow_wr", {wl_addr[0], wl_data[0]}, {16'h0200, 8'hFF});
`ifdef MCU_CARRY_EN
    chk("jc_taken", {illegal, pc}, {1'b0, 16'h0040});
`else
    chk("jc_trap", {illegal, pc}, {1'b1, 16'h0010});
`endif

    // Illegal opcode at address 0
    clear_mem();
    put(0, 32'h3F_00_00_00);
    do_reset(0);
    run_halt(50, cyc);
    chk("ill_cycle", cyc, 6);
    chk("ill_flag", illegal, 1);
    chk("ill_pc", pc, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("ill_no_reads", {mem_rd, 32'(rd_cnt)}, {1'b0, 32'd4});

    // Reset asserted while a store is stalled
    prog_add_st();
    do_reset(2);
    cyc = 0;
    while (mem_wr !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("st_stall_reached", mem_wr, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("st_stall_hold", {mem_wr, mem_addr, mem_wdata},
        {1'b1, 16'h0100, 8'h08});
    #2 rst = 1'b1;
    #1;
    chk_rst("async_reset_drop");
    repeat (2) @(posedge clk);
    mode = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("refetch_start", {mem_rd, mem_addr}, {1'b1, 16'h0000});
    run_halt(200, cyc);
    chk("refetch_halt_cycle", cyc, 30);
    chk("refetch_wr", {32'(wr_cnt), wl_data[0]}, {32'd1, 8'h08});

    // Carry chain into ADC, or trap without carry support
    clear_mem();
    put(0,  32'h03_01_FF_00);
    put(4,  32'h03_02_01_00);
    put(8,  32'h05_01_02_03);
    put(12, 32'h0F_05_06_07);
    put(16, 32'h02_07_03_00);
    put(20, 32'h0D_00_80_00);
    put(24, 32'h0E_00_80_00);
    do_reset(0);
    run_halt(300, cyc);
`ifdef MCU_CARRY_EN
    chk("adc_wr", {32'(wr_cnt), wl_addr[0], wl_data[0]},
        {32'd1, 16'h0300, 8'h01});
    chk("adc_flags_pc", {illegal, pc}, {1'b0, 16'd28});
`else
    chk("adc_trap", {illegal, pc}, {1'b1, 16'd12});
    chk("adc_trap_no_wr", wr_cnt, 0);
`endif

    // Shifts incl. shift by DATA_W, LD and MOV
    clear_mem();
    put(8'h00, 32'h03_01_81_00);
    put(8'h04, 32'h03_02_01_00);
    put(8'h08, 32'h0A_01_02_03);
    put(8'h0C, 32'h0B_01_02_04);
    put(8'h10, 32'h03_05_08_00);
    put(8'h14, 32'h0A_01_05_06);
    put(8'h18, 32'h0D_00_40_00);
    put(8'h40, 32'h02_03_00_A0);
    put(8'h44, 32'h02_04_00_A1);
    put(8'h48, 32'h01_07_00_90);
    put(8'h4C, 32'h04_09_07_00);
    put(8'h50, 32'h02_09_00_A2);
    mem[16'h0090] = 8'h3C;
    do_reset(0);
    run_halt(400, cyc);
    chk("shl_wr", {wl_addr[0], wl_data[0]}, {16'h00A0, 8'h02});
    chk("shr_wr", {wl_addr[1], wl_data[1]}, {16'h00A1, 8'h40});
    chk("ld_mov_wr", {wl_addr[2], wl_data[2]}, {16'h00A2, 8'h3C});
    chk("shift_pc", {illegal, pc}, {1'b0, 16'h0054});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
